// File: rtl/regfile_sb_pkg.sv
// Shared register-file definitions: default sizing, the hardwired-zero index
// and the configuration record used by the decode-stage register file.
package regfile_sb_pkg;

    localparam int          DEFAULT_DATA_WIDTH = 32;
    localparam int          DEFAULT_NUM_REGS   = 32;
    localparam int unsigned REG_ZERO           = 0;

    typedef struct packed {
        int unsigned data_width;
        int unsigned num_regs;
        logic        bypass;
        logic        zero_reg;
    } regfile_cfg_t;

    // True when idx names the register that is hardwired to zero.
    function automatic logic isZeroIndex(input logic zeroReg, input int unsigned idx);
        return zeroReg && (idx == REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus into the scoreboarded register file.
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    logic                  ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0] ctrl_writeReg;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic                  ctrl_issueEnable;
    logic [ADDR_WIDTH-1:0] ctrl_issueReg;
    logic [ADDR_WIDTH-1:0] ctrl_readRegA;
    logic [ADDR_WIDTH-1:0] ctrl_readRegB;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic [DATA_WIDTH-1:0] data_readRegB;
    logic                  busy_A;
    logic                  busy_B;
    logic                  hazard;
    logic [ADDR_WIDTH:0]   pending_count;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_issueEnable, ctrl_issueReg, ctrl_readRegA, ctrl_readRegB,
        input  data_readRegA, data_readRegB, busy_A, busy_B, hazard, pending_count
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_issueEnable, ctrl_issueReg, ctrl_readRegA, ctrl_readRegB,
        output data_readRegA, data_readRegB, busy_A, busy_B, hazard, pending_count
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for in-flight writes plus a running count of them.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic                  issueEnable,
    input  logic [ADDR_WIDTH-1:0] issueReg,
    output logic [NUM_REGS-1:0]   busy,
    output logic [ADDR_WIDTH:0]   pendingCount
);

    logic [NUM_REGS-1:0] busyReg;
    logic [NUM_REGS-1:0] busyNext;
    logic [ADDR_WIDTH:0] pendingCountReg;
    logic                issueValid;
    logic                countInc;
    logic                countDec;

    assign issueValid = issueEnable && !isZeroIndex(ZERO_REG, 32'(issueReg));

    // A new issue supersedes a completing write to the same register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (ZERO_REG && gi == REG_ZERO) begin : g_zero
                assign busyNext[gi] = 1'b0;
            end else begin : g_live
                assign busyNext[gi] = (issueValid && issueReg == ADDR_WIDTH'(gi)) ||
                                      (busyReg[gi] && !(writeEnable && writeReg == ADDR_WIDTH'(gi)));
            end
        end
    endgenerate

    assign countInc = issueValid && !busyReg[issueReg];
    assign countDec = writeEnable && busyReg[writeReg] &&
                      !(issueValid && issueReg == writeReg);

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            busyReg         <= '0;
            pendingCountReg <= '0;
        end else begin
            busyReg         <= busyNext;
            pendingCountReg <= pendingCountReg + (ADDR_WIDTH+1)'(countInc)
                                               - (ADDR_WIDTH+1)'(countDec);
        end
    end

    assign busy         = busyReg;
    assign pendingCount = pendingCountReg;

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file: two combinational read ports, one write port,
// optional write-to-read bypass and a busy scoreboard driving the stall.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter bit BYPASS     = 1'b1,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic         clock,
    input  logic         ctrl_reset,
    regfile_sb_if.slave  bus
);

    localparam regfile_cfg_t CFG = '{
        data_width: DATA_WIDTH,
        num_regs:   NUM_REGS,
        bypass:     BYPASS,
        zero_reg:   ZERO_REG
    };

    logic [DATA_WIDTH-1:0] memReg [NUM_REGS];
    logic [NUM_REGS-1:0]   busyVec;
    logic [ADDR_WIDTH-1:0] rdIdx  [2];
    logic                  writeLive;

    assign writeLive = bus.ctrl_writeEnable &&
                       !isZeroIndex(CFG.zero_reg, 32'(bus.ctrl_writeReg));

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                memReg[i] <= '0;
            end
        end else if (writeLive) begin
            memReg[bus.ctrl_writeReg] <= bus.data_writeReg;
        end
    end

    assign rdIdx[0] = bus.ctrl_readRegA;
    assign rdIdx[1] = bus.ctrl_readRegB;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic                  hit;
            logic [DATA_WIDTH-1:0] data;
            logic                  busy;

            assign hit = CFG.bypass && bus.ctrl_writeEnable && (bus.ctrl_writeReg == rdIdx[gi]);

            always_comb begin
                data = memReg[rdIdx[gi]];
                if (hit) begin
                    data = bus.data_writeReg;
                end
                if (isZeroIndex(CFG.zero_reg, 32'(rdIdx[gi]))) begin
                    data = '0;
                end
            end

            // A write completing this cycle is forwarded, so it must not stall.
            assign busy = busyVec[rdIdx[gi]] && !hit;
        end
    endgenerate

    assign bus.data_readRegA = g_port[0].data;
    assign bus.data_readRegB = g_port[1].data;
    assign bus.busy_A        = g_port[0].busy;
    assign bus.busy_B        = g_port[1].busy;
    assign bus.hazard        = g_port[0].busy | g_port[1].busy;

    regfile_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .writeEnable  (bus.ctrl_writeEnable),
        .writeReg     (bus.ctrl_writeReg),
        .issueEnable  (bus.ctrl_issueEnable),
        .issueReg     (bus.ctrl_issueReg),
        .busy         (busyVec),
        .pendingCount (bus.pending_count)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Drives a bypassing and a non-bypassing register file with identical traffic
// and compares both against an array-based model of the register file.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst;

    regfile_sb_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) bpIf ();
    regfile_sb_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) nbIf ();

    regfile_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .BYPASS(1'b1), .ZERO_REG(1'b1)) dutBp (
        .clock      (clk),
        .ctrl_reset (rst),
        .bus        (bpIf.slave)
    );

    regfile_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .BYPASS(1'b0), .ZERO_REG(1'b1)) dutNb (
        .clock      (clk),
        .ctrl_reset (rst),
        .bus        (nbIf.slave)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mRegs [NR];
    bit            mBusy [NR];
    int            checks = 0;
    int            passes = 0;
    int            fails  = 0;
    int            stepNo = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(mBusy[i]);
        return n;
    endfunction

    function automatic logic [DW-1:0] expData(input bit byp, input bit we, input int wr,
                                              input logic [DW-1:0] wd, input int ra);
        if (ra == 0) return '0;
        if (byp && we && wr == ra) return wd;
        return mRegs[ra];
    endfunction

    function automatic bit expBusy(input bit byp, input bit we, input int wr, input int ra);
        return mBusy[ra] && !(byp && we && wr == ra);
    endfunction

    task automatic checkDut(input string name, input bit byp,
                            input logic [DW-1:0] dA, input logic [DW-1:0] dB,
                            input logic bA, input logic bB, input logic hz, input logic [5:0] pc,
                            input bit we, input int wr, input logic [DW-1:0] wd,
                            input int ra, input int rb);
        bit eA, eB;
        eA = expBusy(byp, we, wr, ra);
        eB = expBusy(byp, we, wr, rb);
        chk($sformatf("%s s%0d readA", name, stepNo), 64'(dA), 64'(expData(byp, we, wr, wd, ra)));
        chk($sformatf("%s s%0d readB", name, stepNo), 64'(dB), 64'(expData(byp, we, wr, wd, rb)));
        chk($sformatf("%s s%0d busyA", name, stepNo), 64'(bA), 64'(eA));
        chk($sformatf("%s s%0d busyB", name, stepNo), 64'(bB), 64'(eB));
        chk($sformatf("%s s%0d hazard", name, stepNo), 64'(hz), 64'(eA | eB));
        chk($sformatf("%s s%0d pending", name, stepNo), 64'(pc), 64'(modelCount()));
    endtask

    // One clock of traffic: drive, check combinational outputs, then advance the model.
    task automatic step(input bit r, input bit we, input int wr, input logic [DW-1:0] wd,
                        input bit ie, input int ir, input int ra, input int rb, input bit doCheck);
        rst = r;
        bpIf.ctrl_writeEnable = we;  nbIf.ctrl_writeEnable = we;
        bpIf.ctrl_writeReg    = 5'(wr); nbIf.ctrl_writeReg = 5'(wr);
        bpIf.data_writeReg    = wd;  nbIf.data_writeReg    = wd;
        bpIf.ctrl_issueEnable = ie;  nbIf.ctrl_issueEnable = ie;
        bpIf.ctrl_issueReg    = 5'(ir); nbIf.ctrl_issueReg = 5'(ir);
        bpIf.ctrl_readRegA    = 5'(ra); nbIf.ctrl_readRegA = 5'(ra);
        bpIf.ctrl_readRegB    = 5'(rb); nbIf.ctrl_readRegB = 5'(rb);
        @(negedge clk);
        $display("step %0d rst=%0d we=%0d wr=%0d wd=0x%08h ie=%0d ir=%0d ra=%0d rb=%0d",
                 stepNo, r, we, wr, wd, ie, ir, ra, rb);
        if (doCheck) begin
            checkDut("bp", 1'b1, bpIf.data_readRegA, bpIf.data_readRegB, bpIf.busy_A, bpIf.busy_B,
                     bpIf.hazard, bpIf.pending_count, we, wr, wd, ra, rb);
            checkDut("nb", 1'b0, nbIf.data_readRegA, nbIf.data_readRegB, nbIf.busy_A, nbIf.busy_B,
                     nbIf.hazard, nbIf.pending_count, we, wr, wd, ra, rb);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NR; i++) begin
                mRegs[i] = '0;
                mBusy[i] = 1'b0;
            end
        end else begin
            if (we && wr != 0) mRegs[wr] = wd;
            if (we) mBusy[wr] = 1'b0;
            if (ie && ir != 0) mBusy[ir] = 1'b1;
        end
        stepNo++;
        #1;
    endtask

    function automatic int pickReg();
        return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NR-1));
    endfunction

    initial begin
        step(1, 0, 0, '0, 0, 0, 0, 0, 0);

        // Everything reads zero and idle after reset.
        for (int i = 0; i < NR; i++) step(0, 0, 0, '0, 0, 0, i, NR-1-i, 1);

        // Plain write, then the hardwired zero register.
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1);
        step(0, 0, 0, '0, 0, 0, 5, 0, 1);
        step(0, 1, 0, 32'h1, 0, 0, 0, 0, 1);
        step(0, 0, 0, '0, 0, 0, 0, 5, 1);

        // Same-cycle visibility of a write differs between the two instances.
        step(0, 1, 7, 32'h1234, 0, 0, 7, 7, 1);
        step(0, 0, 0, '0, 0, 0, 7, 5, 1);

        // Issue marks busy, completing write clears it.
        step(0, 0, 0, '0, 1, 3, 3, 0, 1);
        step(0, 0, 0, '0, 0, 0, 3, 3, 1);
        step(0, 1, 3, 32'hAAAA5555, 0, 0, 3, 3, 1);
        step(0, 0, 0, '0, 0, 0, 3, 7, 1);

        // Re-issue over a completing write keeps the register busy; r0 never busy.
        step(0, 0, 0, '0, 1, 9, 9, 9, 1);
        step(0, 1, 9, 32'h99, 1, 9, 9, 3, 1);
        step(0, 0, 0, '0, 0, 0, 9, 9, 1);
        step(0, 0, 0, '0, 1, 0, 0, 9, 1);
        step(0, 0, 0, '0, 0, 0, 0, 9, 1);

        // Reset wins over a simultaneous write and issue.
        step(0, 0, 0, '0, 1, 1, 1, 2, 1);
        step(0, 0, 0, '0, 1, 2, 1, 2, 1);
        step(0, 0, 0, '0, 1, 4, 4, 2, 1);
        step(1, 1, 2, 32'h22, 1, 6, 2, 6, 1);
        step(0, 0, 0, '0, 0, 0, 2, 6, 1);
        step(0, 0, 0, '0, 0, 0, 1, 4, 1);

        // Random traffic with collisions biased towards a few low registers.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), pickReg(), $urandom,
                 1'($urandom_range(0, 1)), pickReg(), pickReg(), pickReg(), 1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised register file with 2 combinational read ports and 1 write port. Adds three things over the fixed 32x32 file: an optional same-cycle write-to-read bypass, a per-register busy scoreboard for pending writes, and an outstanding-write counter. It sits in the proc decode stage. Decode issues a destination register, which marks it busy; writeback clears it. Decode stalls on the hazard output.

Parameters:
DATA_WIDTH, 32, bits per register
NUM_REGS, 32, register count; power of 2, >= 2
ADDR_WIDTH, $clog2(NUM_REGS), register index width (derived; do not override)
BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads show the stored value only
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy

Ports:
clock  in  1  single clock; all state updates on the rising edge
ctrl_reset  in  1  synchronous, active-high reset
ctrl_writeEnable  in  1  writeback write strobe
ctrl_writeReg  in  ADDR_WIDTH  write index
data_writeReg  in  DATA_WIDTH  write data
ctrl_issueEnable  in  1  decode issued an instruction with a destination register
ctrl_issueReg  in  ADDR_WIDTH  destination index to mark busy
ctrl_readRegA  in  ADDR_WIDTH  read index A
ctrl_readRegB  in  ADDR_WIDTH  read index B
data_readRegA  out  DATA_WIDTH  read data A (combinational)
data_readRegB  out  DATA_WIDTH  read data B (combinational)
busy_A  out  1  source A has a pending write
busy_B  out  1  source B has a pending write
hazard  out  1  busy_A | busy_B
pending_count  out  ADDR_WIDTH+1  number of busy registers

Behaviour:
- Reset (synchronous, active-high):
  - At the edge where ctrl_reset=1, all registers, busy bits and pending_count go to 0.
  - Reset overrides a same-cycle write or issue.
  - After reset, every read returns 0 and busy_A, busy_B, hazard and pending_count are 0.
- Write: on the edge with ctrl_writeEnable=1, regs[ctrl_writeReg] <= data_writeReg.
  - If ZERO_REG=1 and ctrl_writeReg=0, the write is dropped.
- Read: combinational, zero latency; data_readRegX = regs[ctrl_readRegX].
  - ZERO_REG=1 and index 0 gives 0 regardless of any write.
- Bypass (BYPASS=1): if ctrl_writeEnable=1 and ctrl_writeReg equals ctrl_readRegX (and the index is not a forced-zero register), data_readRegX = data_writeReg in that same cycle.
  - Ports A and B bypass independently.
- Scoreboard, per register r, at each edge:
  - Write to r without an issue to r: busy[r] <= 0.
  - Issue to r: busy[r] <= 1. Issue wins over a simultaneous write to the same r, because the newer producer supersedes the completing one.
  - Write and issue to different registers: both take effect.
  - Issue to an already-busy r: r stays busy, no double count.
  - Write to a non-busy r: allowed; busy stays 0.
  - ZERO_REG=1 and r=0: never busy.
- busy_X = busy[ctrl_readRegX] AND NOT (BYPASS=1 AND ctrl_writeEnable=1 AND ctrl_writeReg=ctrl_readRegX). This is combinational. A completing write that is bypassed does not stall.
- pending_count tracks the popcount of the busy bits as a registered counter.
  - Per edge it changes by +1 (newly set bit), -1 (cleared bit), 0 or net 0.
  - It must equal the popcount of busy[] at all times and never wrap.
  - Maximum value: NUM_REGS-1 when ZERO_REG=1, NUM_REGS otherwise.
- Width rules: indices are unsigned; there are no out-of-range indices because NUM_REGS is a power of 2. Data is stored unmodified.

Decomposition:
- A shared proc package holds:
  - default DATA_WIDTH and NUM_REGS constants;
  - the REG_ZERO index constant;
  - a regfile_cfg_t struct (data_width, num_regs, bypass, zero_reg) for top-level configuration.
- One sub-module, regfile_scoreboard, is natural: the busy[] vector, the set/clear priority logic and pending_count. The storage and read/bypass muxing stay in regfile_sb.

Test Plan:
1. Reset then read all indices -> every data_readRegX = 0; busy_A = busy_B = hazard = 0; pending_count = 0.
2. Write 0xDEADBEEF to r5, and next cycle read A=5, B=0 -> data_readRegA = 0xDEADBEEF, data_readRegB = 0. Then write 0x1 to r0 and read r0 -> 0 (ZERO_REG=1).
3. BYPASS=1: in one cycle, write 0x1234 to r7 and read A=7 -> data_readRegA = 0x1234 that cycle. Same with BYPASS=0 -> old value; 0x1234 appears the next cycle.
4. Issue r3, next cycle read A=3 -> busy_A = 1, hazard = 1, pending_count = 1. Write r3 -> with BYPASS=1, busy_A = 0 in the write cycle; busy bit clears at the edge; pending_count = 0.
5. Issue r9 and write r9 in the same cycle while r9 is busy -> r9 stays busy, pending_count unchanged. Issue r0 -> never busy, count unchanged.
6. Issue r1, r2, r4 on successive cycles, then assert ctrl_reset together with a write to r2 and an issue of r6 -> all busy bits 0, pending_count = 0, r2 reads 0.
